regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; successor of the single-write/two-read core register file.
- Configurable width, depth, and read/write port count.
- Adds write-to-read bypass, write-port priority and a per-register busy scoreboard for in-flight producers.
- Sits in the decode/operand-fetch stage: read ports feed the ALU operand muxes; write ports are driven from writeback lanes.

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   addr_t;
  typedef logic [XLEN_DEF-1:0] data_t;

  // The match helper works on padded vectors so one function serves every port count.
  localparam int MAX_WR = 16;
  localparam int MAX_AW = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] port;
  } wr_match_t;

  function automatic wr_match_t find_wr_match(
    input logic [MAX_WR-1:0]             en,
    input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0]             a
  );
    wr_match_t m;
    m = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (en[i] && (addr[i] == a)) begin
        m.hit  = 1'b1;
        m.port = 4'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight producers, plus a registered busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS    = NREGS_DEF,
  parameter int  NWR      = 2,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NWR-1:0]         wr_en_i,
  input  logic [NWR-1:0][AW-1:0] wr_addr_i,
  input  logic                   sb_set_i,
  input  logic [AW-1:0]          sb_set_addr_i,
  output logic [NREGS-1:0]       busy_o,
  output logic [AW:0]            busy_cnt_o
);

  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;

  // Writes retire producers; a set in the same cycle is a newer producer and wins.
  always_comb begin
    busy_next = busy_o;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en_i[k]) busy_next[wr_addr_i[k]] = 1'b0;
    end
    if (sb_set_i) busy_next[sb_set_addr_i] = 1'b1;
    if (ZERO_REG) busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o     <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy_o     <= busy_next;
      busy_cnt_o <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEF,
  parameter int  NREGS    = NREGS_DEF,
  parameter int  NRD      = 2,
  parameter int  NWR      = 2,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic [NWR-1:0]           wr_en_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_set_addr_i,
  output logic [AW:0]              busy_cnt_o
);

  logic [NREGS-1:0][XLEN-1:0]      regs;
  logic [NREGS-1:0]                busy_vec;
  logic [MAX_WR-1:0]               en_pad;
  logic [MAX_WR-1:0][MAX_AW-1:0]   addr_pad;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .sb_set_i      (sb_set_i),
    .sb_set_addr_i (sb_set_addr_i),
    .busy_o        (busy_vec),
    .busy_cnt_o    (busy_cnt_o)
  );

  // Later ports are assigned last, so the highest-index port wins on a collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && !(ZERO_REG && (wr_addr_i[k] == '0))) begin
          regs[wr_addr_i[k]] <= wr_data_i[k];
        end
      end
    end
  end

  always_comb begin
    en_pad   = '0;
    addr_pad = '0;
    for (int k = 0; k < NWR; k++) begin
      en_pad[k]   = wr_en_i[k];
      addr_pad[k] = MAX_AW'(wr_addr_i[k]);
    end
  end

  // A same-cycle write forwards its data and retires the busy bit, unless a new producer is issued.
  always_comb begin
    wr_match_t m;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRD; p++) begin
      m = find_wr_match(en_pad, addr_pad, MAX_AW'(rd_addr_i[p]));
      if (!rst_i && !(ZERO_REG && (rd_addr_i[p] == '0))) begin
        rd_data_o[p] = regs[rd_addr_i[p]];
        rd_busy_o[p] = busy_vec[rd_addr_i[p]];
        if (BYPASS && m.hit) begin
          for (int k = 0; k < NWR; k++) begin
            if (m.port == 4'(k)) rd_data_o[p] = wr_data_i[k];
          end
          if (!(sb_set_i && (sb_set_addr_i == rd_addr_i[p]))) rd_busy_o[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_mp;

  localparam int K_DATA    = 0;
  localparam int K_BUSY    = 1;
  localparam int K_CNT     = 2;
  localparam int K_DATA_NB = 3;
  localparam int K_BUSY_NB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data, rd_data_nb;
  logic [1:0]       rd_busy, rd_busy_nb;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             sb_set;
  logic [4:0]       sb_set_addr;
  logic [5:0]       busy_cnt, busy_cnt_nb;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [31:0] actual;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_mp #(.BYPASS(1'b1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_busy_o     (rd_busy),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .sb_set_i      (sb_set),
    .sb_set_addr_i (sb_set_addr),
    .busy_cnt_o    (busy_cnt)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk_i         (clk),
    .rst_i         (rst),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data_nb),
    .rd_busy_o     (rd_busy_nb),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .sb_set_i      (sb_set),
    .sb_set_addr_i (sb_set_addr),
    .busy_cnt_o    (busy_cnt_nb)
  );

  // Monitor: outputs are combinational, so every cycle's expectations are settled by the negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_DATA:    actual = rd_data[e.port];
        K_BUSY:    actual = {31'b0, rd_busy[e.port]};
        K_CNT:     actual = {26'b0, busy_cnt};
        K_DATA_NB: actual = rd_data_nb[e.port];
        default:   actual = {31'b0, rd_busy_nb[e.port]};
      endcase
      checks++;
      if (actual !== e.value) begin
        errors++;
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, actual, e.value, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                               input logic [31:0] wd0, input logic [31:0] wd1,
                               input logic set, input logic [4:0] sa,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en       = we;
    wr_addr[0]  = wa0;
    wr_addr[1]  = wa1;
    wr_data[0]  = wd0;
    wr_data[1]  = wd1;
    sb_set      = set;
    sb_set_addr = sa;
    rd_addr[0]  = ra0;
    rd_addr[1]  = ra1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, ra0, ra1);
  endtask

  task automatic checkOutput(input int kind, input int port, input logic [31:0] value, input string name);
    exp_t x;
    x.cyc   = cyc;
    x.kind  = kind;
    x.port  = port;
    x.value = value;
    x.name  = name;
    exp_q.push_back(x);
  endtask

  initial begin
    idle(5'd0, 5'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Load r5 and mark it busy, then hit it with reset mid-operation
    applyStimulus(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd5, 5'd5, 5'd5);
    step();
    idle(5'd5, 5'd5);
    checkOutput(K_DATA, 0, 32'hDEAD_BEEF, "pre_reset_data");
    checkOutput(K_BUSY, 0, 32'd1, "pre_reset_busy");
    checkOutput(K_CNT, 0, 32'd1, "pre_reset_cnt");
    step();
    rst = 1'b1;
    checkOutput(K_DATA, 0, 32'h0, "reset_data");
    checkOutput(K_BUSY, 0, 32'd0, "reset_busy");
    checkOutput(K_CNT, 0, 32'd0, "reset_cnt");
    checkOutput(K_DATA_NB, 1, 32'h0, "reset_data_nb");
    step();
    rst = 1'b0;
    checkOutput(K_DATA, 0, 32'h0, "post_reset_data");
    checkOutput(K_BUSY, 1, 32'd0, "post_reset_busy");
    step();
    checkOutput(K_CNT, 0, 32'd0, "post_reset_cnt");
    checkOutput(K_DATA, 1, 32'h0, "post_reset_data2");

    // Plain write then read on both ports
    applyStimulus(2'b01, 5'd7, 5'd0, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    idle(5'd7, 5'd7);
    checkOutput(K_DATA, 0, 32'h1234_5678, "r7_port0");
    checkOutput(K_DATA, 1, 32'h1234_5678, "r7_port1");
    checkOutput(K_DATA_NB, 1, 32'h1234_5678, "r7_port1_nb");
    step();

    // Same-address collision: port 1 wins, both in bypass and in the array
    applyStimulus(2'b11, 5'd3, 5'd3, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 5'd0, 5'd3, 5'd3);
    checkOutput(K_DATA, 1, 32'h5555_5555, "collision_bypass");
    checkOutput(K_DATA_NB, 1, 32'h0, "collision_nobypass_old");
    step();
    idle(5'd3, 5'd3);
    checkOutput(K_DATA, 0, 32'h5555_5555, "collision_array");
    checkOutput(K_DATA_NB, 0, 32'h5555_5555, "collision_array_nb");
    step();

    // Bypass vs no-bypass on r9
    applyStimulus(2'b01, 5'd9, 5'd0, 32'hCAFE_0001, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    checkOutput(K_DATA, 0, 32'hCAFE_0001, "r9_bypass");
    checkOutput(K_DATA_NB, 0, 32'h0, "r9_nobypass_old");
    step();
    idle(5'd9, 5'd9);
    checkOutput(K_DATA_NB, 0, 32'hCAFE_0001, "r9_nobypass_after");
    checkOutput(K_DATA, 1, 32'hCAFE_0001, "r9_after");
    step();

    // Zero register ignores writes and bypass
    applyStimulus(2'b10, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput(K_DATA, 1, 32'h0, "r0_no_bypass");
    checkOutput(K_DATA_NB, 1, 32'h0, "r0_nb");
    step();
    idle(5'd0, 5'd0);
    checkOutput(K_DATA, 0, 32'h0, "r0_after_write");
    step();

    // Scoreboard set, clear, and set-wins-over-clear on r4
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
    checkOutput(K_BUSY, 0, 32'd0, "r4_busy_before_set");
    step();
    idle(5'd4, 5'd4);
    checkOutput(K_BUSY, 0, 32'd1, "r4_busy_set_p0");
    checkOutput(K_BUSY, 1, 32'd1, "r4_busy_set_p1");
    checkOutput(K_CNT, 0, 32'd1, "cnt_after_set");
    step();
    applyStimulus(2'b10, 5'd0, 5'd4, 32'h0, 32'h0000_0044, 1'b0, 5'd0, 5'd4, 5'd4);
    checkOutput(K_BUSY, 0, 32'd0, "r4_busy_bypass_clear");
    checkOutput(K_BUSY_NB, 0, 32'd1, "r4_busy_nb_still");
    checkOutput(K_DATA, 0, 32'h0000_0044, "r4_data_bypass");
    step();
    idle(5'd4, 5'd4);
    checkOutput(K_BUSY, 0, 32'd0, "r4_busy_cleared");
    checkOutput(K_CNT, 0, 32'd0, "cnt_after_clear");
    step();
    applyStimulus(2'b01, 5'd4, 5'd0, 32'h0000_0088, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
    checkOutput(K_BUSY, 0, 32'd0, "r4_set_and_write_same_cycle");
    step();
    idle(5'd4, 5'd4);
    checkOutput(K_BUSY, 0, 32'd1, "r4_set_wins");
    checkOutput(K_CNT, 0, 32'd1, "cnt_set_wins");
    checkOutput(K_DATA, 0, 32'h0000_0088, "r4_data_written");
    step();

    // Fill the scoreboard; r4 is already busy so it adds nothing when re-set
    for (int i = 1; i < 32; i++) begin
      applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'(i), 5'd4, 5'd4);
      step();
      checkOutput(K_CNT, 0, (i < 4) ? 32'(i + 1) : 32'(i), $sformatf("fill_cnt_r%0d", i));
    end
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd31);
    checkOutput(K_BUSY, 0, 32'd0, "r0_never_busy");
    checkOutput(K_BUSY, 1, 32'd1, "r31_busy");
    step();
    idle(5'd0, 5'd31);
    checkOutput(K_CNT, 0, 32'd31, "cnt_full_after_r0_set");
    checkOutput(K_BUSY, 0, 32'd0, "r0_not_busy_after_set");
    step();
    checkOutput(K_CNT, 0, 32'd31, "cnt_full_stable");
    step();
    step();

    if (exp_q.size() != 0) begin
      $display("[TB] FAIL unchecked_expectations: got %0d pending expected 0", exp_q.size());
      checks += exp_q.size();
      errors += exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
